nn_layer_window_framer: RTL
===========================

# nn_layer_window_framer

Input-side framer for the fully-connected ECG layers. It accepts an 8-bit sample or activation stream over a valid/ready handshake and assembles a sliding window of N_IN values in 24-bit lanes. It presents the window to a layer of `nodeL_K` neurons (the A0x..A(N-1)x inputs), holds it stable across the neuron pipeline latency, then strobes when the layer outputs (NKx) are valid.

## Interface

Parameters:
- N_IN, 30, window length / number of lanes (= neuron fan-in)
- DW, 24, lane width, matches neuron A inputs
- SW, 8, input sample width, matches neuron output range 0..255
- STRIDE, 10, new samples accepted between consecutive windows (1..N_IN)
- LAT, 3, neuron pipeline latency in cycles (input reg, sum reg, output reg)
- FCW, 16, frame counter width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  synchronous restart of window fill
- s_valid  in  1  input sample valid
- s_ready  out  1  framer can accept a sample
- s_data  in  SW  input sample, unsigned
- a_flat  out  N_IN*DW  window; lane i at bits [i*DW +: DW], lane 0 oldest
- a_valid  out  1  window complete and held stable
- o_strobe  out  1  one-cycle pulse: layer outputs valid this cycle
- frame_cnt  out  FCW  completed windows, wraps modulo 2^FCW

## Operation

- Accept a sample when s_valid && s_ready. Zero-extend it to DW bits into lane N_IN-1; all lanes shift down one (lane i <= lane i+1); lane 0 is discarded.
- FSM states: FILL, PRESENT, SLIDE.
  - FILL: s_ready=1, a_valid=0; cnt counts accepted samples; on the N_IN-th acceptance -> PRESENT, lat_cnt=0.
  - PRESENT: s_ready=0, a_valid=1, lanes frozen; lat_cnt increments 0..LAT; o_strobe=1 when lat_cnt==LAT; frame_cnt++ on that cycle; next -> SLIDE, cnt=0.
  - SLIDE: s_ready=1, a_valid=0; on the STRIDE-th acceptance -> PRESENT, lat_cnt=0.
- s_ready = (state==FILL || state==SLIDE) && !flush.
- Flush in any state: -> FILL, cnt=0, lat_cnt=0, lanes cleared to 0, a_valid=0, no strobe that cycle. frame_cnt is kept. Any sample offered that cycle is not accepted.
- Gaps in s_valid only stall counting; no timeout.
- Reset: state FILL, all lanes 0, cnt=0, lat_cnt=0, a_valid=0, o_strobe=0, frame_cnt=0. s_ready reads 1 from the first cycle after reset deasserts.

## Timing

- Sample accepted at edge k is visible in lane N_IN-1 in cycle k+1.
- Completing acceptance at edge k: a_valid=1 in cycles k+1..k+1+LAT (LAT+1 cycles). o_strobe=1 in cycle k+1+LAT. This matches neuron output validity: A captured at the end of k+1, N visible at k+1+LAT.
- The next sample can be accepted no earlier than the edge ending cycle k+2+LAT.
- Window throughput = STRIDE + LAT + 1 cycles minimum per frame.
- Reset asserted mid-PRESENT: no o_strobe, state FILL on the next cycle.
- frame_cnt wraps 2^FCW-1 -> 0 without side effects.

## Structure

- Shared package nn_layer_pkg:
  - NN_DW=24, NN_SW=8
  - framer state enum {FILL, PRESENT, SLIDE}
  - lane slice helper function
  - neuron latency constant NN_NODE_LAT=3, used as the LAT default
- One sub-module, nn_window_shift: an N_IN-lane shift register with shift enable, clear and zero-extend. The FSM and counters live in the top module.

## Test plan

- Defaults, feed 1..30 back-to-back -> a_valid from the cycle after sample 30; lane0=1, lane29=30; o_strobe exactly once, in the 4th a_valid cycle; frame_cnt=1.
- Continue with 31..40 -> second window lane0=11, lane29=40; strobe; frame_cnt=2. s_valid held high during PRESENT -> s_ready=0 and no sample consumed; data 41 is accepted first in SLIDE.
- Random s_valid gaps (50% duty) over 3 windows -> window contents identical to the gap-free run; exactly 3 strobes.
- Flush after 5 SLIDE samples -> a_valid=0 and lanes=0. The next 30 samples 100..129 give lane0=100, lane29=129; frame_cnt unchanged by the flush.
- Reset asserted in PRESENT when lat_cnt=1 -> no strobe, all outputs at reset values. A refill of 30 samples then works normally.
- FCW=4, run 16 windows -> frame_cnt goes 15 -> 0 on the 16th strobe.

Source files
------------

// File: rtl/nn_layer_pkg.sv
// Shared constants and types for the fully-connected ECG layer datapath.
// Lane geometry and neuron latency are kept here so the framer matches the neurons.
package nn_layer_pkg;

    localparam int NN_DW       = 24;
    localparam int NN_SW       = 8;
    localparam int NN_NODE_LAT = 3;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRESENT = 2'd1,
        SLIDE   = 2'd2
    } framer_state_t;

    // Bit offset of a lane inside a flattened window vector.
    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/nn_window_shift.sv
// N_IN-lane shift register: new zero-extended sample enters the top lane,
// lane 0 (oldest) falls out. Clear zeroes every lane.
module nn_window_shift
    import nn_layer_pkg::*;
#(
    parameter int N_IN = 30,
    parameter int DW   = NN_DW,
    parameter int SW   = NN_SW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic [SW-1:0]        din,
    output logic [N_IN*DW-1:0]   lanes
);

    logic [DW-1:0] lane_q [N_IN];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < N_IN; i++) lane_q[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < N_IN - 1; i++) lane_q[i] <= lane_q[i+1];
            lane_q[N_IN-1] <= DW'(din);
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_flat
        assign lanes[lane_lsb(g, DW) +: DW] = lane_q[g];
    end

endmodule

// File: rtl/nn_layer_window_framer.sv
// Sliding-window framer feeding a fully-connected neuron layer: fills N_IN lanes,
// holds the window for the neuron latency, strobes when layer outputs are valid.
module nn_layer_window_framer
    import nn_layer_pkg::*;
#(
    parameter int N_IN   = 30,
    parameter int DW     = NN_DW,
    parameter int SW     = NN_SW,
    parameter int STRIDE = 10,
    parameter int LAT    = NN_NODE_LAT,
    parameter int FCW    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [SW-1:0]      s_data,
    output logic [N_IN*DW-1:0] a_flat,
    output logic               a_valid,
    output logic               o_strobe,
    output logic [FCW-1:0]     frame_cnt
);

    localparam int CW = $clog2(N_IN + 1);
    localparam int LW = $clog2(LAT + 2);

    framer_state_t state;
    logic [CW-1:0] cnt;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] fill_last;
    logic          accept;
    logic          lat_done;

    assign s_ready   = (state == FILL || state == SLIDE) && !flush;
    assign accept    = s_valid && s_ready;
    assign lat_done  = (state == PRESENT) && (lat_cnt == LW'(LAT));
    assign o_strobe  = lat_done && !flush;
    // First window needs the full fan-in; later windows only STRIDE fresh samples.
    assign fill_last = (state == FILL) ? CW'(N_IN - 1) : CW'(STRIDE - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            cnt       <= '0;
            lat_cnt   <= '0;
            a_valid   <= 1'b0;
            frame_cnt <= '0;
        end else if (flush) begin
            state   <= FILL;
            cnt     <= '0;
            lat_cnt <= '0;
            a_valid <= 1'b0;
        end else begin
            case (state)
                FILL, SLIDE: begin
                    if (accept) begin
                        if (cnt == fill_last) begin
                            state   <= PRESENT;
                            cnt     <= '0;
                            lat_cnt <= '0;
                            a_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (lat_done) begin
                        state     <= SLIDE;
                        cnt       <= '0;
                        a_valid   <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    a_valid <= 1'b0;
                end
            endcase
        end
    end

    nn_window_shift #(
        .N_IN (N_IN),
        .DW   (DW),
        .SW   (SW)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .shift_en (accept),
        .din      (s_data),
        .lanes    (a_flat)
    );

endmodule
